// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
// Takes one frame of 2**N_LOG2 complex FFT results in bit-reversed index order
// and re-emits it in natural order. Two banks form a ping-pong buffer: one bank
// fills while the other drains, so consecutive frames stream without gaps.
// Optional feature macro: FFT_REORDER_FRAME_MARK_EN adds out_last / out_index,
// registered alongside the output data.
`timescale 1ns/1ps

module fft_bitrev_reorder #(
    parameter int N_LOG2 = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_push,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              in_stall,
    output logic              out_push,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    input  logic              out_stall
`ifdef FFT_REORDER_FRAME_MARK_EN
    ,
    output logic              out_last,
    output logic [N_LOG2-1:0] out_index
`endif
);

    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);

    logic [2*DATA_W-1:0] r_mem [2][N];
    logic [1:0]          r_full;
    logic                r_wbank;
    logic                r_rbank;
    logic [N_LOG2-1:0]   r_widx;
    logic [N_LOG2-1:0]   r_ridx;

    logic                w_wr;
    logic                w_ld;
    logic                w_wrLast;
    logic                w_rdLast;
    logic [N_LOG2-1:0]   w_wrAddr;
    logic [2*DATA_W-1:0] w_rdWord;
    logic [1:0]          w_fullNext;

    // Reverse the bit order of an index within the frame.
    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] idx);
        logic [N_LOG2-1:0] rev;
        rev = '0;
        for (int b = 0; b < N_LOG2; b++) begin
            rev[b] = idx[N_LOG2-1-b];
        end
        return rev;
    endfunction

    // Stall depends only on registered bank state, never on out_stall.
    assign in_stall = r_full[r_wbank];
    assign w_wr     = in_push & ~r_full[r_wbank];
    assign w_wrLast = w_wr & (r_widx == LAST_IDX);
    assign w_wrAddr = bitrev(r_widx);

    // The output register may load when a full bank is waiting and the
    // register is either empty or being consumed this cycle.
    assign w_ld     = r_full[r_rbank] & (~out_push | ~out_stall);
    assign w_rdLast = w_ld & (r_ridx == LAST_IDX);
    assign w_rdWord = r_mem[r_rbank][r_ridx];

    // Sample storage: arriving sample k lands at natural position bitrev(k).
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wbank][w_wrAddr] <= {in_real, in_imag};
        end
    end

    // Bank-full flags: writer sets its bank, reader clears its bank; they
    // always target different banks so both updates can apply together.
    always_comb begin
        w_fullNext = r_full;
        if (w_rdLast) begin
            w_fullNext[r_rbank] = 1'b0;
        end
        if (w_wrLast) begin
            w_fullNext[r_wbank] = 1'b1;
        end
    end

    // Full-flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_fullNext;
        end
    end

    // Write pointer: advance per accepted sample, switch bank at frame end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_widx  <= '0;
            r_wbank <= 1'b0;
        end else if (w_wr) begin
            r_widx <= r_widx + 1'b1;
            if (w_wrLast) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    // Read pointer: advance per load, switch bank after the last entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ridx  <= '0;
            r_rbank <= 1'b0;
        end else if (w_ld) begin
            r_ridx <= r_ridx + 1'b1;
            if (w_rdLast) begin
                r_rbank <= ~r_rbank;
            end
        end
    end

    // Output register stage: load new data, drop valid when consumed, hold under stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_push <= 1'b0;
            out_real <= '0;
            out_imag <= '0;
        end else if (w_ld) begin
            out_push <= 1'b1;
            out_real <= w_rdWord[2*DATA_W-1:DATA_W];
            out_imag <= w_rdWord[DATA_W-1:0];
        end else if (!out_stall) begin
            out_push <= 1'b0;
        end
    end

`ifdef FFT_REORDER_FRAME_MARK_EN
    // Frame markers travel with the data: natural bin number and last-bin flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_last  <= 1'b0;
            out_index <= '0;
        end else if (w_ld) begin
            out_last  <= (r_ridx == LAST_IDX);
            out_index <= r_ridx;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard testbench for fft_bitrev_reorder.
`timescale 1ns/1ps

module tb_fft_bitrev_reorder;

    localparam int N_LOG2 = 4;
    localparam int DATA_W = 16;
    localparam int N      = 16;

    typedef struct {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        int                idx;
    } expItem_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_push;
    logic [DATA_W-1:0] in_real;
    logic [DATA_W-1:0] in_imag;
    logic              in_stall;
    logic              out_push;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_imag;
    logic              out_stall;
`ifdef FFT_REORDER_FRAME_MARK_EN
    logic              out_last;
    logic [N_LOG2-1:0] out_index;
`endif

    fft_bitrev_reorder #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_push   (in_push),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .in_stall  (in_stall),
        .out_push  (out_push),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_stall (out_stall)
`ifdef FFT_REORDER_FRAME_MARK_EN
        ,
        .out_last  (out_last),
        .out_index (out_index)
`endif
    );

    always #5 clk = ~clk;

    expItem_t          expQ[$];
    int                captureQ[$];
    logic [DATA_W-1:0] frameRe[N];
    logic [DATA_W-1:0] frameIm[N];
    int frameFill;
    int nChecks;
    int nFails;
    int cycle;
    int stallMode;
    int acceptCount;
    int lastAcceptCycle;
    int xferCount;
    int firstXferCycle;
    int lastXferCycle;
    bit inStallSeen;
    bit drvDone;
    int refSeq[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    // Free-running cycle counter.
    always @(posedge clk) cycle <= cycle + 1;

    // Bit reversal computed arithmetically from the index value.
    function automatic int bitRev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < N_LOG2; b++) begin
            r = r * 2 + ((v >> b) & 1);
        end
        return r;
    endfunction

    // Compare one value, count it, report on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a full frame in arrival order becomes natural order,
    // natural bin n holding the sample that arrived at position bitRev(n).
    task automatic recordAccept(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
        expItem_t e;
        frameRe[frameFill] = re;
        frameIm[frameFill] = im;
        frameFill++;
        if (frameFill == N) begin
            for (int n = 0; n < N; n++) begin
                e.re  = frameRe[bitRev(n)];
                e.im  = frameIm[bitRev(n)];
                e.idx = n;
                expQ.push_back(e);
            end
            frameFill = 0;
        end
    endtask

    // Present one sample and keep it until the DUT accepts it (bounded wait).
    task automatic applyStimulus(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
        bit done;
        done    = 0;
        in_push = 1'b1;
        in_real = re;
        in_imag = im;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (!in_stall) begin
                recordAccept(re, im);
                acceptCount++;
                lastAcceptCycle = cycle;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_push = 1'b0;
        if (!done) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL acceptTimeout: got in_stall=1, expected acceptance");
        end
    endtask

    // Wait until every expected output has been delivered (bounded).
    task automatic waitDrain();
        bit done;
        done = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (expQ.size() == 0 && frameFill == 0) done = 1;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("drainComplete", {63'd0, done}, 64'd1);
    endtask

    function automatic logic [DATA_W-1:0] pickVal();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 16'h7fff;
        if (r == 1) return 16'h8000;
        return DATA_W'($urandom);
    endfunction

    // Downstream backpressure driver: off, held, or 50% random.
    initial begin
        out_stall = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_stall = (stallMode == 1) || (stallMode == 2 && $urandom_range(0, 1) == 1);
        end
    end

    // Monitor: pops the scoreboard on each output transfer and checks that a
    // stalled output stays frozen.
    initial begin
        expItem_t e;
        bit prevHeld;
        logic [2*DATA_W-1:0] heldData;
        prevHeld = 0;
        heldData = '0;
        forever begin
            @(negedge clk);
            if (in_stall) inStallSeen = 1;
            if (!reset_n) begin
                prevHeld = 0;
            end else begin
                if (prevHeld) begin
                    checkOutput("holdPush", {63'd0, out_push}, 64'd1);
                    checkOutput("holdData", {32'd0, out_real, out_imag}, {32'd0, heldData});
                end
                prevHeld = out_push && out_stall;
                heldData = {out_real, out_imag};
                if (out_push && !out_stall) begin
                    if (xferCount == 0) firstXferCycle = cycle;
                    lastXferCycle = cycle;
                    xferCount++;
                    captureQ.push_back(int'(out_real));
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL unexpectedOutput: got real=%0h, expected no output", out_real);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("outReal", {48'd0, out_real}, {48'd0, e.re});
                        checkOutput("outImag", {48'd0, out_imag}, {48'd0, e.im});
`ifdef FFT_REORDER_FRAME_MARK_EN
                        checkOutput("outIndex", {60'd0, out_index}, 64'(e.idx));
                        checkOutput("outLast", {63'd0, out_last}, {63'd0, e.idx == N - 1});
`endif
                    end
                end
            end
        end
    end

    task automatic resetWindowCounters();
        xferCount   = 0;
        acceptCount = 0;
        inStallSeen = 0;
        captureQ.delete();
    endtask

    task automatic checkRefSeq(input string name);
        checkOutput({name, "Count"}, 64'(captureQ.size()), 64'd16);
        for (int i = 0; i < 16 && i < captureQ.size(); i++) begin
            checkOutput(name, 64'(captureQ[i]), 64'(refSeq[i]));
        end
    endtask

    initial begin
        int base;
        nChecks = 0; nFails = 0; cycle = 0; frameFill = 0; stallMode = 0;
        reset_n = 1'b0; in_push = 1'b0; in_real = '0; in_imag = '0;
        resetWindowCounters();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetOutPush", {63'd0, out_push}, 64'd0);
        checkOutput("resetOutReal", {48'd0, out_real}, 64'd0);
        checkOutput("resetOutImag", {48'd0, out_imag}, 64'd0);
        checkOutput("resetInStall", {63'd0, in_stall}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, real = arrival index.
        $display("[TB] single frame reorder");
        resetWindowCounters();
        for (int k = 0; k < N; k++) applyStimulus(DATA_W'(k), '0);
        waitDrain();
        checkRefSeq("t1Seq");
        checkOutput("t1Latency", 64'(firstXferCycle - lastAcceptCycle), 64'd2);

        // Three back-to-back frames with no backpressure.
        $display("[TB] back-to-back frames");
        resetWindowCounters();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < N; k++) applyStimulus(DATA_W'(16 * f + k), DATA_W'(-k));
        waitDrain();
        checkOutput("t2NoInStall", {63'd0, inStallSeen}, 64'd0);
        checkOutput("t2Count", 64'(xferCount), 64'd48);
        checkOutput("t2NoGaps", 64'(lastXferCycle - firstXferCycle), 64'd47);

        // Downstream held stalled while three frames are offered.
        $display("[TB] held backpressure");
        resetWindowCounters();
        stallMode = 1;
        @(posedge clk);
        #2;
        drvDone = 0;
        fork
            begin
                for (int f = 0; f < 3; f++)
                    for (int k = 0; k < N; k++) applyStimulus(DATA_W'(100 + 16 * f + k), DATA_W'(k));
                drvDone = 1;
            end
        join_none
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkOutput("t3Accepted", 64'(acceptCount), 64'd32);
        checkOutput("t3InStall", {63'd0, in_stall}, 64'd1);
        checkOutput("t3OutPush", {63'd0, out_push}, 64'd1);
        checkOutput("t3NoXfer", 64'(xferCount), 64'd0);
        stallMode = 0;
        for (int t = 0; t < 2000 && !drvDone; t++) @(posedge clk);
        waitDrain();
        checkOutput("t3Count", 64'(xferCount), 64'd48);

        // Random traffic on both sides with extreme values.
        $display("[TB] random traffic");
        resetWindowCounters();
        stallMode = 2;
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < N; k++) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
                applyStimulus(pickVal(), pickVal());
            end
        end
        waitDrain();
        stallMode = 0;
        checkOutput("t4Count", 64'(xferCount), 64'd320);

        // Reset mid-frame.
        $display("[TB] reset mid-frame and mid-drain");
        for (int k = 0; k < 7; k++) applyStimulus(DATA_W'(k + 50), '0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("t5ResetPushA", {63'd0, out_push}, 64'd0);
        expQ.delete();
        frameFill = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-drain.
        resetWindowCounters();
        for (int k = 0; k < N; k++) applyStimulus(DATA_W'(k + 200), '0);
        for (int t = 0; t < 200 && xferCount < 5; t++) @(negedge clk);
        #2;
        checkOutput("t5Draining", {63'd0, out_push}, 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("t5ResetPushB", {63'd0, out_push}, 64'd0);
        checkOutput("t5ResetReal", {48'd0, out_real}, 64'd0);
        expQ.delete();
        frameFill = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fresh frame after reset reproduces the single-frame order.
        resetWindowCounters();
        for (int k = 0; k < N; k++) applyStimulus(DATA_W'(k), '0);
        waitDrain();
        checkRefSeq("t5Seq");

        base = 0;
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
